// File: rtl/dma_bus_pkg.sv
// rtl/dma_bus_pkg.sv - shared states, size defaults and word-select helper for the DMA bus arbiter
package dma_bus_pkg;

   localparam int WORD_SIZE_DEF   = 16;
   localparam int BURST_WORDS_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      GRANTED,
      WRITE,
      RELEASE
   } arb_state_t;

   // Bit offset of word idx inside a packed block; word 0 sits in the low bits.
   function automatic int word_lsb(input int idx, input int word_size);
      return idx * word_size;
   endfunction

endpackage

// File: rtl/dma_burst_writer.sv
// rtl/dma_burst_writer.sv - latches one DMA block and streams it word by word onto the memory write port
module dma_burst_writer
   import dma_bus_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int BURST_WORDS = BURST_WORDS_DEF
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          start,
   input  logic [WORD_SIZE-1:0]          blk_addr,
   input  logic [BURST_WORDS*WORD_SIZE-1:0] blk_data,
   input  logic                          mem_ready,
   output logic                          mem_write,
   output logic [WORD_SIZE-1:0]          mem_addr,
   output logic [WORD_SIZE-1:0]          mem_wdata,
   output logic                          last_accept,
   output logic                          done
);

   localparam int IW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BURST_WORDS - 1);

   logic [WORD_SIZE-1:0]             base;
   logic [BURST_WORDS*WORD_SIZE-1:0] blk;
   logic [IW-1:0]                    idx;
   logic [IW-1:0]                    idx_nxt;

   assign idx_nxt     = idx + 1'b1;
   assign last_accept = mem_write && mem_ready && (idx == LAST_IDX);

   // mem_write doubles as the busy flag; a low mem_ready leaves address and data untouched.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         base      <= '0;
         blk       <= '0;
         idx       <= '0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            base      <= blk_addr;
            blk       <= blk_data;
            idx       <= '0;
            mem_write <= 1'b1;
            mem_addr  <= blk_addr;
            mem_wdata <= blk_data[word_lsb(0, WORD_SIZE) +: WORD_SIZE];
         end else if (mem_write && mem_ready) begin
            if (idx == LAST_IDX) begin
               mem_write <= 1'b0;
               done      <= 1'b1;
            end else begin
               idx       <= idx_nxt;
               mem_addr  <= base + WORD_SIZE'(idx_nxt);
               mem_wdata <= blk[word_lsb(int'(idx_nxt), WORD_SIZE) +: WORD_SIZE];
            end
         end
      end
   end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - BR/BG arbiter between CPU and DMA with burst serializer
// Optional grant-cycle limit with forced release when ARB_GRANT_TIMEOUT_EN is defined.
module dma_bus_arbiter
   import dma_bus_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int BURST_WORDS = BURST_WORDS_DEF,
   parameter int MAX_GRANT   = 64
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             BR,
   output logic                             BG,
   input  logic                             cpu_busy,
   output logic                             cpu_hold,
   input  logic                             dma_wr_valid,
   input  logic [WORD_SIZE-1:0]             dma_addr,
   input  logic [BURST_WORDS*WORD_SIZE-1:0] dma_data,
   output logic                             dma_wr_ack,
   output logic                             mem_sel,
   output logic                             mem_write,
   output logic [WORD_SIZE-1:0]             mem_addr,
   output logic [WORD_SIZE-1:0]             mem_wdata,
   input  logic                             mem_ready,
   output logic                             grant_timeout
);

   arb_state_t state;
   logic       timeout_hit;
   logic       br_low_needed;
   logic       wr_start;
   logic       wr_last;

   assign wr_start = (state == GRANTED) && dma_wr_valid && !timeout_hit;

   dma_burst_writer #(
      .WORD_SIZE   (WORD_SIZE),
      .BURST_WORDS (BURST_WORDS)
   ) u_writer (
      .CLK         (CLK),
      .RST         (RST),
      .start       (wr_start),
      .blk_addr    (dma_addr),
      .blk_data    (dma_data),
      .mem_ready   (mem_ready),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .last_accept (wr_last),
      .done        (dma_wr_ack)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         BG       <= 1'b0;
         cpu_hold <= 1'b0;
         mem_sel  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (BR && !br_low_needed) begin
                  state    <= DRAIN;
                  cpu_hold <= 1'b1;
               end
            end
            DRAIN: begin
               if (!BR) begin
                  state <= RELEASE;
               end else if (!cpu_busy) begin
                  state   <= GRANTED;
                  BG      <= 1'b1;
                  mem_sel <= 1'b1;
               end
            end
            GRANTED: begin
               // A pending block beats a dropped BR; only the grant limit overrides it.
               if (timeout_hit) begin
                  state   <= RELEASE;
                  BG      <= 1'b0;
                  mem_sel <= 1'b0;
               end else if (dma_wr_valid) begin
                  state <= WRITE;
               end else if (!BR) begin
                  state   <= RELEASE;
                  BG      <= 1'b0;
                  mem_sel <= 1'b0;
               end
            end
            WRITE: begin
               if (wr_last) begin
                  state <= GRANTED;
               end
            end
            RELEASE: begin
               state    <= IDLE;
               cpu_hold <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               BG       <= 1'b0;
               cpu_hold <= 1'b0;
               mem_sel  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_GRANT_TIMEOUT_EN
   localparam int CW = $clog2(MAX_GRANT + 1);
   localparam logic [CW-1:0] GRANT_LAST = CW'(MAX_GRANT - 1);

   logic [CW-1:0] grant_cnt;

   assign timeout_hit = (state == GRANTED) && (grant_cnt >= GRANT_LAST);

   // Counter saturates at the limit so a burst that overruns it releases on its return to GRANTED.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         grant_cnt     <= '0;
         grant_timeout <= 1'b0;
         br_low_needed <= 1'b0;
      end else begin
         if (state == DRAIN) begin
            grant_cnt <= '0;
         end else if (((state == GRANTED) || (state == WRITE)) && (grant_cnt < GRANT_LAST)) begin
            grant_cnt <= grant_cnt + 1'b1;
         end
         if (timeout_hit) begin
            grant_timeout <= 1'b1;
            br_low_needed <= 1'b1;
         end else if (!BR) begin
            br_low_needed <= 1'b0;
         end
      end
   end
`else
   logic unused_max_grant;

   assign unused_max_grant = ^MAX_GRANT;
   assign timeout_hit      = 1'b0;
   assign br_low_needed    = 1'b0;
   assign grant_timeout    = 1'b0;
`endif

endmodule
